// File: rtl/kyber_modmul_pipe.sv
// kyber_modmul_pipe: pipelined Barrett modular multiplier (q = 3329) with valid/ready and tag sideband.
// Define KYBER_MODMUL_FULL_REDUCE_EN to add the final conditional subtract stage (r in [0, Q), latency 4).
module kyber_modmul_pipe #(
  parameter int Q = 3329,
  parameter int W = 12,
  parameter int K = 24,
  parameter int M = 5039,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       r,
  output logic [TAG_W-1:0] out_tag
);
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
  localparam int S = 4;
`else
  localparam int S = 3;
`endif
  logic en;
  logic [S-1:0] vld;
  logic [TAG_W-1:0] tg [S];
  logic [2*W-1:0] c1, c2;
  logic [W-1:0] t2;
  logic [W:0] u3;
  logic [2*W+K-1:0] cm;
  // Floor-Barrett quotient estimate: t is floor(c/Q) or one less, so u lands in [0, 2Q)
  assign cm = (2*W+K)'(c1) * (2*W+K)'(M);
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign out_valid = vld[S-1];
  assign out_tag = tg[S-1];
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
  logic [W:0] r4;
  assign r = r4;
`else
  assign r = u3;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      c1 <= '0;
      c2 <= '0;
      t2 <= '0;
      u3 <= '0;
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
      r4 <= '0;
`endif
      for (int i = 0; i < S; i++) tg[i] <= '0;
    end else if (en) begin
      vld <= {vld[S-2:0], in_valid};
      tg[0] <= in_tag;
      for (int i = 1; i < S; i++) tg[i] <= tg[i-1];
      c1 <= (2*W)'(a) * (2*W)'(b);
      c2 <= c1;
      t2 <= W'(cm >> K);
      u3 <= (W+1)'(c2 - (2*W)'(t2) * (2*W)'(Q));
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
      r4 <= (u3 >= (W+1)'(Q)) ? u3 - (W+1)'(Q) : u3;
`endif
    end
  end
endmodule

// File: tb/tb_kyber_modmul_pipe.sv
// tb_kyber_modmul_pipe: random and directed checks of kyber_modmul_pipe against a queue-based reference model.
module tb_kyber_modmul_pipe;
  localparam int Q = 3329;
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
  localparam int LAT = 4;
  localparam int MAXR = 1;
`else
  localparam int LAT = 3;
  localparam int MAXR = 3330;
`endif
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [11:0] a = 0, b = 0;
  logic [7:0] in_tag = 0, out_tag;
  logic [12:0] r;
  int nvec = 0, nerr = 0, n_in = 0, n_out = 0;
  typedef struct {int r; int tag; int m;} exp_t;
  exp_t q[$];
  exp_t e;
  bit hold_prev = 0;
  int prev_r, prev_tag;

  always #5 clk = ~clk;

  kyber_modmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .r(r), .out_tag(out_tag)
  );

  function automatic int model(int x, int y);
    longint c = longint'(x) * longint'(y);
`ifdef KYBER_MODMUL_FULL_REDUCE_EN
    return int'(c % Q);
`else
    longint t = (c * 5039) >> 24;
    return int'(c - t * Q);
`endif
  endfunction

  function void chk(bit ok, string nm, int act, int expv);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) hold_prev = 0;
    else begin
      chk(in_ready == (!out_valid || out_ready), "in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
      if (hold_prev) begin
        chk(out_valid, "hold_valid", int'(out_valid), 1);
        chk(int'(r) == prev_r, "hold_r", int'(r), prev_r);
        chk(int'(out_tag) == prev_tag, "hold_tag", int'(out_tag), prev_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk(0, "unexpected_out", int'(r), -1);
        else begin
          e = q.pop_front();
          chk(int'(r) == e.r, "r", int'(r), e.r);
          chk(int'(out_tag) == e.tag, "tag", int'(out_tag), e.tag);
`ifndef KYBER_MODMUL_FULL_REDUCE_EN
          chk(int'(r) < 2*Q && int'(r) % Q == e.m, "lazy_congruence", int'(r), e.m);
`endif
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(int'(a), int'(b)), int'(in_tag), (int'(a) * int'(b)) % Q});
        n_in++;
      end
      hold_prev = out_valid && !out_ready;
      prev_r = int'(r);
      prev_tag = int'(out_tag);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int x, int y, int t);
    in_valid = v;
    a = 12'(x);
    b = 12'(y);
    in_tag = 8'(t);
  endtask

  task automatic single(int x, int y, int t, int er, string nm);
    int n;
    drive(1, x, y, t);
    cyc();
    drive(0, 0, 0, 0);
    n = 1;
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    chk(n == LAT, {nm, "_latency"}, n, LAT);
    chk(int'(r) == er, nm, int'(r), er);
    chk(int'(out_tag) == t, {nm, "_tag"}, int'(out_tag), t);
    cyc();
  endtask

  task automatic drain();
    drive(0, 0, 0, 0);
    out_ready = 1;
    for (int k = 0; k < 50 && q.size() > 0; k++) cyc();
    chk(q.size() == 0, "drain", q.size(), 0);
  endtask

  initial begin
    int sent, n0;
    bit acc;
    #2;
    chk(!out_valid, "reset_valid", int'(out_valid), 0);
    chk(r == 0, "reset_r", int'(r), 0);
    chk(out_tag == 0, "reset_tag", int'(out_tag), 0);
    #10 rst = 0;
    #1 chk(in_ready, "ready_after_reset", int'(in_ready), 1);
    cyc();
    single(3328, 3328, 8'hA5, MAXR, "max");
    single(0, 2999, 1, 0, "zero");
    single(1234, 2, 2, 2468, "small");
    single(1, 1, 3, 1, "one");
    for (int i = 0; i < 100; i++) begin
      drive(1, int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), i);
      #1;
      chk(in_ready, "stream_ready", int'(in_ready), 1);
      if (i >= LAT) chk(out_valid, "stream_out_valid", int'(out_valid), 1);
      cyc();
    end
    drain();
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 60 && (sent < 8 || q.size() > 0); c++) begin
      out_ready = !(c >= 5 && c < 10);
      if (sent < 8) drive(1, int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), sent);
      else drive(0, 0, 0, 0);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) chk(!in_ready, "bp_ready_low", int'(in_ready), 0);
      cyc();
      if (acc) sent++;
    end
    out_ready = 1;
    chk(n_out - n0 == 8, "bp_count", n_out - n0, 8);
    drain();
    for (int i = 0; i < 3; i++) begin
      drive(1, 100 + i, 200 + i, 8'h30 + i);
      cyc();
    end
    drive(0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk(!out_valid, "rst_async_valid", int'(out_valid), 0);
    chk(r == 0, "rst_async_r", int'(r), 0);
    q.delete();
    @(negedge clk);
    #1 rst = 0;
    cyc();
    chk(!out_valid, "no_stale", int'(out_valid), 0);
    single(5, 7, 8'h55, 35, "after_rst");
    n0 = n_in;
    for (int k = 0; k < 40000 && n_in - n0 < 10000; k++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, 255)));
      out_ready = $urandom_range(0, 9) < 7;
      cyc();
    end
    chk(n_in - n0 >= 10000, "random_accepts", n_in - n0, 10000);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/kyber_modmul_pipe.md
Name: kyber_modmul_pipe

Overview:
- Pipelined modular multiplier for the Kyber NTT datapath (q = 3329).
- Takes two reduced operands a, b in [0, Q) and multiplies them, giving c = a*b.
- Reduces c with a floor-Barrett step and, optionally, a final conditional subtract.
- Sits between the coefficient/twiddle memories and the butterfly adders, with valid/ready handshakes on both ends and a sideband tag carried alongside each result.

Parameters:
- Q, 3329, modulus.
- W, 12, operand width, ceil(log2 Q).
- K, 24, Barrett shift amount; must satisfy (Q-1)^2 < 2^K.
- M, 5039, Barrett constant, floor(2^K / Q).
- TAG_W, 8, width of the sideband tag (e.g. memory address) carried with each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair a, b and in_tag are valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- a  in  W  operand, required < Q.
- b  in  W  operand, required < Q.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result r and out_tag are valid.
- out_ready  in  1  downstream consumes the result this cycle.
- r  out  W+1  result: [0, Q) with FULL_REDUCE_EN, [0, 2Q) without.
- out_tag  out  TAG_W  tag of the operation that produced r.

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-high. While rst is high:
  - every stage valid bit is 0, so out_valid = 0;
  - r = 0 and out_tag = 0;
  - all data registers are 0;
  - in_ready = 1 on release.
- Reset asserted mid-stream discards every in-flight operation; no result is emitted for it.
- Pipeline stages (registers, each with its own valid bit and tag):
  - S1: c = a*b, 2W bits (24).
  - S2: t = (c*M) >> K, W bits; c forwarded.
  - S3: u = c - t*Q, W+1 bits, u in [0, 2Q). Guaranteed because t is in {floor(c/Q)-1, floor(c/Q)} for c < 2^K.
  - S4 (FULL_REDUCE_EN only): r = (u >= Q) ? u - Q : u.
- Latency: 4 cycles with FULL_REDUCE_EN, 3 without, from the accept edge to out_valid, with no stalls.
- Throughput: one result per cycle when out_ready is held high.
- Handshake and stall:
  - Global enable en = !out_valid | out_ready; in_ready = en.
  - Input is accepted on a rising edge with in_valid & in_ready.
  - When en = 0, all stages hold: data, valid bits and tags are frozen.
  - Bubbles are not collapsed: an empty stage still advances only with en.
  - out_valid stays high with r and out_tag stable until out_ready is seen.
- Simultaneous accept and output consume in the same cycle is legal and required, with no bubble inserted.
- Ordering: results leave strictly in acceptance order; each tag stays paired with its own result.
- Arithmetic:
  - All arithmetic is unsigned; products are computed at full width before shifting.
  - No rounding constant is used.
  - The multiplications map to DSP blocks; constant multiplies by M and Q are permitted.
- Out-of-range inputs (a or b >= Q): result is unspecified, but the handshake and ordering rules above still hold.

Optional Feature:
- Macro: KYBER_MODMUL_FULL_REDUCE_EN.
- Defined:
  - S4 conditional subtract is present; r is in [0, Q).
  - Latency is 4.
- Undefined:
  - S4 is absent; r = u, in [0, 2Q) (lazy reduction for downstream adders).
  - Latency is 3; bit W of r may be set.

Test Plan:
- Max case: a = 3328, b = 3328, single pulse, out_ready = 1.
  - With the macro: r = 1 after 4 cycles.
  - Without: r = 3330 after 3 cycles.
- Zero and small values: (0, 2999) -> 0; (1234, 2) -> 2468; (1, 1) -> 1; each with out_tag equal to in_tag.
- Streaming: 100 back-to-back random pairs, out_ready = 1.
  - in_ready stays 1 throughout.
  - One result per cycle, in order, matching a*b mod Q (reduced to [0, 2Q) without the macro).
- Backpressure: stream 8 ops and drop out_ready for 5 cycles mid-stream.
  - in_ready = 0 while out_valid & !out_ready.
  - r and out_tag are held stable.
  - No loss or duplication; tags are 0..7 in order.
- Reset mid-operation: assert rst with 3 ops in flight.
  - out_valid = 0 and r = 0 immediately (asynchronous).
  - After release, the next op (5, 7) returns 35 with no stale outputs.
- Random regression: 10k pairs with random in_valid/out_ready gaps.
  - Scoreboard compares every result against a golden (a*b) % Q model, plus [0, 2Q) range and congruence checks without the macro.
